// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART-driven ALU controller.
// The ALU and the controller both take their default widths and state encoding from here.
package uart_alu_ctrl_pkg;

    localparam int NB_DATA_DEFAULT       = 8;
    localparam int NB_OP_DEFAULT         = 6;
    localparam int TIMEOUT_TICKS_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // The inter-byte timeout only runs while the rest of a started command is awaited.
    function automatic logic is_collecting(input state_t s);
        return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Saturating inter-byte timeout counter driven by baud ticks.
// Expiry is flagged in the same cycle as the tick that reaches the limit.
module uart_alu_timeout #(
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_expired
);

    localparam int NB_COUNT = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [NB_COUNT-1:0] LIMIT    = NB_COUNT'(TIMEOUT_TICKS);
    localparam logic [NB_COUNT-1:0] LIMIT_M1 = NB_COUNT'(TIMEOUT_TICKS - 1);
    localparam logic [NB_COUNT-1:0] ONE      = NB_COUNT'(1);

    logic [NB_COUNT-1:0] count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && i_tick && (count != LIMIT)) begin
            count <= count + ONE;
        end
    end

    assign o_expired = i_enable && ((count == LIMIT) || (i_tick && (count == LIMIT_M1)));

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and an opcode from the UART receiver, latches the ALU
// result and hands it to the transmitter; guards against stalled and overlapping commands.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEFAULT,
    parameter int NB_OP         = NB_OP_DEFAULT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    state_t state;
    state_t next_state;

    logic counting;
    logic cnt_clear;
    logic expired;
    logic timeout_hit;
    logic overrun_hit;
    logic latch_a;
    logic latch_b;
    logic latch_op;
    logic latch_result;

    uart_alu_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (cnt_clear),
        .i_enable (counting),
        .i_tick   (i_tick),
        .o_expired(expired)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_WAIT_A;
        end else begin
            state <= next_state;
        end
    end

    // A received byte always takes priority over a timeout landing in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT_A:  if (i_rx_done) next_state = ST_WAIT_B;
            ST_WAIT_B: begin
                if (i_rx_done)    next_state = ST_WAIT_OP;
                else if (expired) next_state = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_done)    next_state = ST_EXEC;
                else if (expired) next_state = ST_WAIT_A;
            end
            ST_EXEC:    next_state = ST_SEND;
            ST_SEND:    next_state = ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done) next_state = ST_WAIT_A;
            default:    next_state = ST_WAIT_A;
        endcase
    end

    always_comb begin
        latch_a      = 1'b0;
        latch_b      = 1'b0;
        latch_op     = 1'b0;
        latch_result = 1'b0;
        timeout_hit  = 1'b0;
        overrun_hit  = 1'b0;
        o_tx_start   = 1'b0;
        o_busy       = (state != ST_WAIT_A);
        counting     = is_collecting(state);
        cnt_clear    = !counting || i_rx_done;
        case (state)
            ST_WAIT_A:  latch_a = i_rx_done;
            ST_WAIT_B: begin
                latch_b     = i_rx_done;
                timeout_hit = expired && !i_rx_done;
            end
            ST_WAIT_OP: begin
                latch_op    = i_rx_done;
                timeout_hit = expired && !i_rx_done;
            end
            ST_EXEC: begin
                latch_result = 1'b1;
                overrun_hit  = i_rx_done;
            end
            ST_SEND: begin
                o_tx_start  = 1'b1;
                overrun_hit = i_rx_done;
            end
            ST_WAIT_TX: overrun_hit = i_rx_done;
            default: ;
        endcase
    end

    // Operand registers are only written on their own byte, so a timeout leaves them intact.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (latch_a)      o_alu_a   <= i_rx_data;
            if (latch_b)      o_alu_b   <= i_rx_data;
            if (latch_op)     o_alu_op  <= i_rx_data[NB_OP-1:0];
            if (latch_result) o_tx_data <= i_alu_result;
            o_timeout <= timeout_hit;
            o_overrun <= overrun_hit;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small ALU stub and a 16-tick timeout.
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_timeout;
    logic       o_overrun;

    int checks = 0;
    int errors = 0;

    uart_alu_ctrl #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_TICKS(16)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    always #5 i_clock = ~i_clock;

    // ALU stub: 0x20 add, 0x22 subtract, anything else xor.
    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_alu_a + o_alu_b;
            6'h22:   i_alu_result = o_alu_a - o_alu_b;
            default: i_alu_result = o_alu_a ^ o_alu_b;
        endcase
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] rx_byte);
        i_rx_data = rx_byte;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic applyTicks(input int n);
        for (int k = 0; k < n; k++) begin
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            step();
        end
    endtask

    task automatic finishTx();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a"},     32'(o_alu_a),    32'h0);
        checkOutput({tag, "_b"},     32'(o_alu_b),    32'h0);
        checkOutput({tag, "_op"},    32'(o_alu_op),   32'h0);
        checkOutput({tag, "_txd"},   32'(o_tx_data),  32'h0);
        checkOutput({tag, "_start"}, 32'(o_tx_start), 32'h0);
        checkOutput({tag, "_busy"},  32'(o_busy),     32'h0);
        checkOutput({tag, "_tmo"},   32'(o_timeout),  32'h0);
        checkOutput({tag, "_ovr"},   32'(o_overrun),  32'h0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        checkAllZero("reset");
        i_reset = 1'b0;
        step();

        // Stray tx_done while idle does nothing
        finishTx();
        checkOutput("stray_busy",  32'(o_busy),     32'h0);
        checkOutput("stray_start", 32'(o_tx_start), 32'h0);
        checkOutput("stray_ovr",   32'(o_overrun),  32'h0);
        step();
        checkOutput("stray_start2", 32'(o_tx_start), 32'h0);

        // Basic command 5 + 3 = 8
        applyStimulus(8'h05);
        checkOutput("cmd1_a",    32'(o_alu_a), 32'h05);
        checkOutput("cmd1_busy", 32'(o_busy),  32'h1);
        applyStimulus(8'h03);
        checkOutput("cmd1_b", 32'(o_alu_b), 32'h03);
        applyStimulus(8'h20);
        checkOutput("cmd1_op",     32'(o_alu_op),   32'h20);
        checkOutput("cmd1_exec_s", 32'(o_tx_start), 32'h0);
        step();
        checkOutput("cmd1_start", 32'(o_tx_start), 32'h1);
        checkOutput("cmd1_txd",   32'(o_tx_data),  32'h08);
        step();
        checkOutput("cmd1_start_off", 32'(o_tx_start), 32'h0);
        checkOutput("cmd1_wait_busy", 32'(o_busy),     32'h1);
        step();
        finishTx();
        checkOutput("cmd1_idle", 32'(o_busy), 32'h0);

        // Timeout in WAIT_B: A kept, one pulse
        applyStimulus(8'h11);
        applyTicks(15);
        checkOutput("tmo_pre_busy", 32'(o_busy),    32'h1);
        checkOutput("tmo_pre_tmo",  32'(o_timeout), 32'h0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        checkOutput("tmo_pulse", 32'(o_timeout), 32'h1);
        checkOutput("tmo_busy",  32'(o_busy),    32'h0);
        checkOutput("tmo_a",     32'(o_alu_a),   32'h11);
        step();
        checkOutput("tmo_pulse_end", 32'(o_timeout), 32'h0);

        // Idle waits indefinitely
        applyTicks(20);
        checkOutput("idle_busy", 32'(o_busy),    32'h0);
        checkOutput("idle_tmo",  32'(o_timeout), 32'h0);

        // B arrives together with the 16th tick: byte wins
        applyStimulus(8'h0A);
        applyTicks(15);
        i_tick = 1'b1;
        i_rx_data = 8'h07;
        i_rx_done = 1'b1;
        step();
        i_tick = 1'b0;
        i_rx_done = 1'b0;
        checkOutput("race_b",     32'(o_alu_b),   32'h07);
        checkOutput("race_tmo",   32'(o_timeout), 32'h0);
        checkOutput("race_state", 32'(dut.state), 32'(ST_WAIT_OP));
        step();
        checkOutput("race_tmo2", 32'(o_timeout), 32'h0);

        // Opcode keeps only the low 6 bits: 0xE2 -> 0x22, 0x0A - 0x07 = 0x03
        applyStimulus(8'hE2);
        checkOutput("trunc_op", 32'(o_alu_op), 32'h22);
        step();
        checkOutput("sub_start", 32'(o_tx_start), 32'h1);
        checkOutput("sub_txd",   32'(o_tx_data),  32'h03);
        step();

        // Overrun while waiting for the transmitter
        applyStimulus(8'h55);
        checkOutput("ovr_pulse", 32'(o_overrun), 32'h1);
        checkOutput("ovr_txd",   32'(o_tx_data), 32'h03);
        checkOutput("ovr_a",     32'(o_alu_a),   32'h0A);
        checkOutput("ovr_busy",  32'(o_busy),    32'h1);
        step();
        checkOutput("ovr_pulse_end", 32'(o_overrun), 32'h0);
        finishTx();
        checkOutput("ovr_idle", 32'(o_busy), 32'h0);

        // Next command after overrun: 0x0F ^ 0xF0 = 0xFF
        applyStimulus(8'h0F);
        applyStimulus(8'hF0);
        applyStimulus(8'h01);
        step();
        checkOutput("post_ovr_start", 32'(o_tx_start), 32'h1);
        checkOutput("post_ovr_txd",   32'(o_tx_data),  32'hFF);
        step();
        finishTx();

        // Timeout in WAIT_OP: operands unchanged
        applyStimulus(8'h44);
        applyStimulus(8'h66);
        applyTicks(16);
        checkOutput("tmo_op_busy", 32'(o_busy),  32'h0);
        checkOutput("tmo_op_a",    32'(o_alu_a), 32'h44);
        checkOutput("tmo_op_b",    32'(o_alu_b), 32'h66);

        // Asynchronous reset mid-command
        applyStimulus(8'h21);
        applyStimulus(8'h12);
        i_reset = 1'b1;
        #1;
        checkAllZero("async_rst");
        step();
        i_reset = 1'b0;
        step();
        applyStimulus(8'h02);
        applyStimulus(8'h09);
        applyStimulus(8'h20);
        step();
        checkOutput("after_rst_start", 32'(o_tx_start), 32'h1);
        checkOutput("after_rst_txd",   32'(o_tx_data),  32'h0B);
        step();
        finishTx();
        checkOutput("after_rst_idle", 32'(o_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
